bps_gen_multi: RTL and testbench
================================

# bps_gen_multi

Runtime-selectable UART baud-rate generator, the parametrised successor to the fixed-divisor `speed_select` generator. It produces the mid-bit sample/shift strobe `clk_bps` for the UART RX/TX shifters, an end-of-bit strobe, a bit index and a frame-complete strobe. The rate comes from a 5-entry table or a custom divisor, chosen per frame. It sits between the UART control register and the rx/tx shift-register blocks.

## Interface
- `CNT_W`, default 13: counter and divisor width; must hold the largest divisor (5207).
- `FRAME_BITS`, default 10: bits per frame (start + 8 data + stop); range 1..15.
- `clk` in 1: 50 MHz main clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bps_start` in 1: run request, level; high for the duration of a frame.
- `bps_sel` in 3: rate select, sampled only while idle.
- `div_cfg` in CNT_W: custom divisor, used when `bps_sel`=7; sampled only while idle.
- `clk_bps` out 1: one-cycle strobe at bit midpoint.
- `bit_end` out 1: one-cycle strobe at last cycle of each bit.
- `bit_idx` out 4: index of the current bit, 0..FRAME_BITS-1.
- `frame_done` out 1: one-cycle strobe, coincident with `bit_end` of bit FRAME_BITS-1.
- `busy` out 1: registered copy of `bps_start`.

## Operation
- Divisor D, by `bps_sel`:
  - 0 → 5207 (9600)
  - 1 → 2603 (19200)
  - 2 → 1301 (38400)
  - 3 → 867 (57600)
  - 4, 5, 6 → 433 (115200)
  - 7 → `div_cfg`, clamped up to MIN_DIV=15.
- Bit period is D+1 cycles. Half point H = floor(D/2), computed from D by a right shift.
- Idle (`bps_start` low):
  - `div_q` reloads from the selection every cycle.
  - `cnt`=0, `bit_idx`=0.
  - No strobes.
- Run (`bps_start` high):
  - `div_q` is frozen. Changes to `bps_sel`/`div_cfg` mid-frame have no effect until the next idle cycle.
  - `cnt` steps as follows: cnt==div_q → 0, else cnt+1.
- Strobes are registered:
  - `clk_bps` is set on an edge where pre-edge cnt==H and `bps_start`=1.
  - `bit_end` is set on an edge where pre-edge cnt==div_q and `bps_start`=1.
- `bit_idx` increments on each `bit_end`. It wraps from FRAME_BITS-1 to 0 and asserts `frame_done` at that wrap. The generator keeps running until `bps_start` falls.
- `bps_start` falling mid-bit:
  - Next edge clears `cnt` and `bit_idx`.
  - No strobe is generated on or after that edge.
  - A strobe already registered on the previous edge completes its single cycle.
- Reset, any time: all state and outputs go to 0 immediately; `div_q` resets to 433.

## Timing
- E0 is the first rising edge at which `bps_start` is sampled high (cnt=0 before E0).
- First `clk_bps` is high in the cycle following edge E0+H. Subsequent ones follow every D+1 cycles.
- `bit_end` is high in the cycle following edge E0+D, then every D+1 cycles.
- `clk_bps` and `bit_end` are never high together, because H<D holds for D≥15.
- `busy` lags `bps_start` by one cycle.
- Outputs are pure registers; no combinational path from inputs to outputs.

## Structure
- Package `uart_bps_pkg` holds:
  - the five divisor constants;
  - MIN_DIV;
  - the `bps_sel` encodings (SEL_9600..SEL_CUSTOM).
- One sub-module, `bps_div_lut`: combinational mapping of sel and `div_cfg` to the clamped divisor.
- Top level holds the counter, strobe registers and bit counter.

## Test plan
- sel=4, start held: `clk_bps` high at E0+216+1, E0+650+1; `bit_end` at E0+433+1; period 434 cycles.
- sel=0, full frame: 10 `bit_end` strobes 5208 cycles apart; `frame_done` only with the 10th; `bit_idx` sequence 0..9 then 0.
- sel=7, div_cfg=9: clamped to D=15; `clk_bps` at E0+7+1, period 16. Repeat with div_cfg=100: H=50, period 101.
- Change sel 4→0 mid-frame: period stays 434 until `bps_start` drops. The next frame runs at 5208.
- Drop `bps_start` at cnt=100 with sel=4: no `clk_bps` at 216; `cnt`/`bit_idx` are 0 next cycle. Restarting gives a fresh E0 timing.
- Assert `rst_n` low mid-frame, asynchronously between edges: all outputs 0 immediately. After release with start high, timing restarts from E0 at D=433.

Source files
------------

// File: rtl/uart_bps_pkg.sv
// Purpose: shared divisor constants and rate-select encodings for the UART baud generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_bps_pkg;

    // Divisors for a 50 MHz core: bit period is divisor+1 cycles.
    localparam int DIV_9600   = 5207;
    localparam int DIV_19200  = 2603;
    localparam int DIV_38400  = 1301;
    localparam int DIV_57600  = 867;
    localparam int DIV_115200 = 433;

    // Smallest custom divisor accepted. Keeps the half point strictly below
    // the end point so the mid-bit and end-of-bit strobes never coincide.
    localparam int MIN_DIV    = 15;

    // Divisor loaded by reset, so a frame started straight out of reset runs at 115200.
    localparam int RESET_DIV  = DIV_115200;

    // Encodings 5 and 6 are unassigned and fall back to 115200.
    typedef enum logic [2:0] {
        SEL_9600   = 3'd0,
        SEL_19200  = 3'd1,
        SEL_38400  = 3'd2,
        SEL_57600  = 3'd3,
        SEL_115200 = 3'd4,
        SEL_RSV5   = 3'd5,
        SEL_RSV6   = 3'd6,
        SEL_CUSTOM = 3'd7
    } bps_sel_e;

endpackage

// File: rtl/bps_div_lut.sv
// Purpose: maps rate select + custom divisor to the divisor actually used (custom value clamped up).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module bps_div_lut
    import uart_bps_pkg::*;
#(
    parameter int CNT_W = 13
) (
    input  logic [2:0]       sel_i,
    input  logic [CNT_W-1:0] div_cfg_i,
    output logic [CNT_W-1:0] div_o
);

    localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);

    logic [CNT_W-1:0] custom_div;

    // Custom divisors below the minimum are raised to it rather than rejected.
    assign custom_div = (div_cfg_i < MIN_DIV_W) ? MIN_DIV_W : div_cfg_i;

    // Select the table divisor; reserved encodings map to 115200.
    always_comb begin
        div_o = CNT_W'(DIV_115200);
        case (bps_sel_e'(sel_i))
            SEL_9600:   div_o = CNT_W'(DIV_9600);
            SEL_19200:  div_o = CNT_W'(DIV_19200);
            SEL_38400:  div_o = CNT_W'(DIV_38400);
            SEL_57600:  div_o = CNT_W'(DIV_57600);
            SEL_115200: div_o = CNT_W'(DIV_115200);
            SEL_RSV5:   div_o = CNT_W'(DIV_115200);
            SEL_RSV6:   div_o = CNT_W'(DIV_115200);
            SEL_CUSTOM: div_o = custom_div;
            default:    div_o = CNT_W'(DIV_115200);
        endcase
    end

endmodule

// File: rtl/bps_gen_multi.sv
// Purpose: runtime-selectable UART bit timer: mid-bit strobe, end-of-bit strobe, bit index, frame-done.
// Latency: strobes registered, high the cycle after the edge where the count matches; busy lags bps_start by 1.
// Backpressure: none; bps_start is a level run request, dropping it aborts the frame on the next edge.
module bps_gen_multi
    import uart_bps_pkg::*;
#(
    parameter int CNT_W      = 13,
    parameter int FRAME_BITS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bps_start,
    input  logic [2:0]       bps_sel,
    input  logic [CNT_W-1:0] div_cfg,
    output logic             clk_bps,
    output logic             bit_end,
    output logic [3:0]       bit_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] RESET_DIV_W = CNT_W'(RESET_DIV);

    // Divisor chosen by the current select inputs (only used while idle).
    logic [CNT_W-1:0] div_sel;

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_div;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             clk_bps_q, clk_bps_d;
    logic             bit_end_q, bit_end_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q;
    logic             at_half;
    logic             at_end;
    logic             last_bit;

    bps_div_lut #(
        .CNT_W     (CNT_W)
    ) u_div_lut (
        .sel_i     (bps_sel),
        .div_cfg_i (div_cfg),
        .div_o     (div_sel)
    );

    // Half point derived from the frozen divisor, so it cannot drift mid-frame.
    assign half_div = div_q >> 1;
    assign at_half  = (cnt_q == half_div);
    assign at_end   = (cnt_q == div_q);
    assign last_bit = (bit_idx_q == LAST_BIT);

    // Next state: idle reloads the divisor and parks the counters; run steps the bit timer.
    always_comb begin
        div_d        = div_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        clk_bps_d    = 1'b0;
        bit_end_d    = 1'b0;
        frame_done_d = 1'b0;

        if (!bps_start) begin
            // Idle or aborted frame: nothing strobes, next start begins a fresh bit 0.
            div_d     = div_sel;
            cnt_d     = '0;
            bit_idx_d = '0;
        end else begin
            cnt_d     = at_end ? '0 : cnt_q + 1'b1;
            clk_bps_d = at_half;
            bit_end_d = at_end;
            if (at_end) begin
                frame_done_d = last_bit;
                bit_idx_d    = last_bit ? 4'd0 : bit_idx_q + 4'd1;
            end
        end
    end

    // Timer state and registered outputs; reset drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= RESET_DIV_W;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            clk_bps_q    <= 1'b0;
            bit_end_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            clk_bps_q    <= clk_bps_d;
            bit_end_q    <= bit_end_d;
            frame_done_q <= frame_done_d;
            busy_q       <= bps_start;
        end
    end

    assign clk_bps    = clk_bps_q;
    assign bit_end    = bit_end_q;
    assign bit_idx    = bit_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bps_gen_multi.sv
// Purpose: self-checking bench for bps_gen_multi: closed-form timing model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_bps_gen_multi;

    localparam int CNT_W = 13;
    localparam int FB    = 10;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             bps_start = 1'b0;
    logic [2:0]       bps_sel   = 3'd4;
    logic [CNT_W-1:0] div_cfg   = '0;
    logic             clk_bps;
    logic             bit_end;
    logic [3:0]       bit_idx;
    logic             frame_done;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bps_gen_multi #(
        .CNT_W      (CNT_W),
        .FRAME_BITS (FB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bps_start  (bps_start),
        .bps_sel    (bps_sel),
        .div_cfg    (div_cfg),
        .clk_bps    (clk_bps),
        .bit_end    (bit_end),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Free-running edge counter (not reset), used to timestamp strobes.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Rate table as written in the datasheet.
    function automatic int sel_div(input int sel, input int cfg);
        case (sel)
            0:       return 5207;
            1:       return 2603;
            2:       return 1301;
            3:       return 867;
            7:       return (cfg < 15) ? 15 : cfg;
            default: return 433;
        endcase
    endfunction

    // Model: n counts edges since E0; every output is a closed-form function of n and D.
    int m_div = 433;
    int m_n   = -1;
    bit e_clk, e_end, e_fd, e_busy;
    int e_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div = 433; m_n = -1;
            e_clk = 0; e_end = 0; e_fd = 0; e_busy = 0; e_idx = 0;
        end else begin
            e_busy = bps_start;
            if (!bps_start) begin
                m_div = sel_div(int'(bps_sel), int'(div_cfg));
                m_n   = -1;
                e_clk = 0; e_end = 0; e_fd = 0; e_idx = 0;
            end else begin
                m_n++;
                e_clk = ((m_n % (m_div + 1)) == (m_div / 2));
                e_end = ((m_n % (m_div + 1)) == m_div);
                e_fd  = e_end && (((m_n / (m_div + 1)) % FB) == FB - 1);
                e_idx = ((m_n + 1) / (m_div + 1)) % FB;
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("model", int'({clk_bps, bit_end, frame_done, busy, bit_idx}),
            int'({e_clk, e_end, e_fd, e_busy, 4'(e_idx)}));
    end

    // Wait for clk_bps (which=0) or bit_end (which=1); returns the edge index it was registered on.
    task automatic wait_hi(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && clk_bps) || (which == 1 && bit_end)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: strobe %0d not seen within %0d cycles", which, budget);
        end
    endtask

    int e0, at, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({clk_bps, bit_end, frame_done, busy, bit_idx}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // sel=4, start held
        bps_sel = 3'd4;
        repeat (2) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        wait_hi(0, 1000, at); chk("t1_bps0", at - e0, 216);
        wait_hi(1, 1000, at); chk("t1_end0", at - e0, 433);
        chk("t1_idx1", int'(bit_idx), 1);
        wait_hi(0, 1000, at); chk("t1_bps1", at - e0, 650);
        wait_hi(1, 1000, at); chk("t1_end1", at - e0, 867);

        // sel=0, full frame
        bps_start = 1'b0; bps_sel = 3'd0;
        repeat (3) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        for (int k = 1; k <= 10; k++) begin
            wait_hi(1, 6000, at);
            chk("t2_end_at", at - e0, k * 5208 - 1);
            chk("t2_fd", int'(frame_done), (k == 10) ? 1 : 0);
            chk("t2_idx", int'(bit_idx), k % 10);
        end

        // sel=7, div_cfg=9 clamps to 15
        bps_start = 1'b0; bps_sel = 3'd7; div_cfg = 13'd9;
        repeat (2) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        wait_hi(0, 100, at); chk("t3a_bps0", at - e0, 7);
        wait_hi(1, 100, at); chk("t3a_end0", at - e0, 15);
        wait_hi(0, 100, at); chk("t3a_bps1", at - e0, 23);

        // sel=7, div_cfg=100
        bps_start = 1'b0; div_cfg = 13'd100;
        repeat (2) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        wait_hi(0, 300, at); chk("t3b_bps0", at - e0, 50);
        wait_hi(1, 300, at); chk("t3b_end0", at - e0, 100);
        wait_hi(0, 300, at); chk("t3b_bps1", at - e0, 151);

        // sel 4 -> 0 mid-frame: period holds until the next idle
        bps_start = 1'b0; bps_sel = 3'd4;
        repeat (2) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        repeat (100) @(negedge clk);
        bps_sel = 3'd0;
        wait_hi(1, 1000, at); chk("t4_end0", at - e0, 433);
        wait_hi(1, 1000, at); chk("t4_end1", at - e0, 867);
        bps_start = 1'b0;
        repeat (2) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        wait_hi(1, 6000, at); chk("t4_next_end0", at - e0, 5207);

        // Drop start at cnt=100 with sel=4
        bps_start = 1'b0; bps_sel = 3'd4;
        repeat (2) @(negedge clk);
        bps_start = 1'b1; e0 = cyc + 1;
        repeat (100) @(negedge clk);
        bps_start = 1'b0;
        @(negedge clk);
        chk("t5_idle", int'({busy, bit_idx, clk_bps}), 0);
        n = 0;
        repeat (299) begin
            @(negedge clk);
            if (clk_bps) n++;
        end
        chk("t5_no_bps", n, 0);
        bps_start = 1'b1; e0 = cyc + 1;
        wait_hi(0, 1000, at); chk("t5_restart_bps0", at - e0, 216);

        // Async reset mid-frame at sel=1; restart runs at D=433
        bps_start = 1'b0; bps_sel = 3'd1;
        repeat (2) @(negedge clk);
        bps_start = 1'b1;
        repeat (500) @(negedge clk);
        chk("t6_pre_busy", int'(busy), 1);
        #3 rst_n = 1'b0;
        #1 chk("t6_async", int'({clk_bps, bit_end, frame_done, busy, bit_idx}), 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1; e0 = cyc + 1;
        wait_hi(0, 1000, at); chk("t6_bps0", at - e0, 216);
        wait_hi(1, 1000, at); chk("t6_end0", at - e0, 433);

        bps_start = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
